// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-busy freeze and wrong-path squash.
// Stall/flush outputs are combinational; state, bubble counter and perf counters are registered.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_wa,
    input  logic             ex_regWrite,
    input  logic             ex_memOrReg,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        UNUSED   = 2'd3
    } hz_state_t;

    localparam logic [2:0]       LAT_M1  = 3'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hz_state_t        r_state;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;

    hz_state_t        w_next_state;
    logic [2:0]       w_next_cnt;
    logic             w_lu;
    logic             w_in_stall;
    logic             w_bubble;
    logic             w_redirect;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_lu = id_valid && ex_regWrite && ex_memOrReg && (ex_wa != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_wa)) || (id_use_rs2 && (id_rs2 == ex_wa)));

    // MEM_WAIT resumes an interrupted load-use stall when bubbles remain.
    assign w_in_stall = ((r_state == LU_STALL) || (r_state == MEM_WAIT)) && (r_cnt != 3'd0);

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        w_next_state = RUN;
        w_next_cnt   = r_cnt;
        w_bubble     = 1'b0;
        w_redirect   = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next_cnt = 3'd0;
        end else if (mem_busy) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            w_next_state = MEM_WAIT;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_redirect = 1'b1;
            w_next_cnt = 3'd0;
        end else if (w_in_stall) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_flush   = 1'b1;
            w_bubble     = 1'b1;
            w_next_cnt   = r_cnt - 3'd1;
            w_next_state = (r_cnt == 3'd1) ? RUN : LU_STALL;
        end else if (w_lu) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_flush   = 1'b1;
            w_bubble     = 1'b1;
            w_next_cnt   = LAT_M1;
            w_next_state = (LAT_M1 != 3'd0) ? LU_STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_cnt          <= 3'd0;
            r_stall_cycles <= '0;
            r_bubble_cnt   <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
            if (w_redirect) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
            end
        end
    end

    assign hz_state     = r_state;
    assign stall_cycles = r_stall_cycles;
    assign bubble_cnt   = r_bubble_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1 / 32-bit counters, LOAD_LAT=3 / 8-bit counters)
// share stimulus; a bubble-count model checks every cycle, directed scenarios pin literal values.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_wa;
    logic       ex_regWrite;
    logic       ex_memOrReg;
    logic       ex_redirect;
    logic       mem_busy;

    logic [1:0]  d_pc, d_ifs, d_iff, d_ids, d_idf, d_exs;
    logic [1:0]  d_hz [2];
    logic [31:0] sc1, bc1, rc1;
    logic [7:0]  sc3, bc3, rc3;
    logic [31:0] d_sc [2];
    logic [31:0] d_bc [2];
    logic [31:0] d_rc [2];

    assign d_sc[0] = sc1;
    assign d_bc[0] = bc1;
    assign d_rc[0] = rc1;
    assign d_sc[1] = {24'd0, sc3};
    assign d_bc[1] = {24'd0, bc3};
    assign d_rc[1] = {24'd0, rc3};

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wa(ex_wa),
        .ex_regWrite(ex_regWrite), .ex_memOrReg(ex_memOrReg), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .pc_stall(d_pc[0]), .ifid_stall(d_ifs[0]), .ifid_flush(d_iff[0]),
        .idex_stall(d_ids[0]), .idex_flush(d_idf[0]), .exmem_stall(d_exs[0]),
        .hz_state(d_hz[0]), .stall_cycles(sc1), .bubble_cnt(bc1), .redirect_cnt(rc1)
    );

    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wa(ex_wa),
        .ex_regWrite(ex_regWrite), .ex_memOrReg(ex_memOrReg), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .pc_stall(d_pc[1]), .ifid_stall(d_ifs[1]), .ifid_flush(d_iff[1]),
        .idex_stall(d_ids[1]), .idex_flush(d_idf[1]), .exmem_stall(d_exs[1]),
        .hz_state(d_hz[1]), .stall_cycles(sc3), .bubble_cnt(bc3), .redirect_cnt(rc3)
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[u%0d] at %0t: got %0d, want %0d", name, (k == 0) ? 1 : 3, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          lat  [2] = '{1, 3};
    logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    int          m_rem [2] = '{0, 0};
    int          m_hz  [2] = '{0, 0};
    logic [31:0] m_sc  [2] = '{0, 0};
    logic [31:0] m_bc  [2] = '{0, 0};
    logic [31:0] m_rc  [2] = '{0, 0};
    logic m_lu;
    logic e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs;
    int   n_rem, n_hz;

    always @(negedge clk) begin
        if (chk_en) begin
            m_lu = id_valid && ex_regWrite && ex_memOrReg && (ex_wa != 5'd0) &&
                   ((id_use_rs1 && id_rs1 == ex_wa) || (id_use_rs2 && id_rs2 == ex_wa));
            for (int k = 0; k < 2; k++) begin
                {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs} = 6'b0;
                n_rem = m_rem[k];
                n_hz  = 0;
                if (rst) begin
                    e_iff = 1'b1; e_idf = 1'b1; n_rem = 0;
                end else if (mem_busy) begin
                    e_pc = 1'b1; e_ifs = 1'b1; e_ids = 1'b1; e_exs = 1'b1; n_hz = 2;
                end else if (ex_redirect) begin
                    e_iff = 1'b1; e_idf = 1'b1; n_rem = 0;
                end else if (m_rem[k] > 0 || m_lu) begin
                    e_pc = 1'b1; e_ifs = 1'b1; e_idf = 1'b1;
                    n_rem = (m_rem[k] > 0) ? m_rem[k] - 1 : lat[k] - 1;
                    n_hz  = (n_rem > 0) ? 1 : 0;
                end
                chk("hz_state", k, 32'(d_hz[k]), 32'(m_hz[k]));
                chk("stall_cycles", k, d_sc[k], m_sc[k]);
                chk("bubble_cnt", k, d_bc[k], m_bc[k]);
                chk("redirect_cnt", k, d_rc[k], m_rc[k]);
                chk("pc_stall", k, 32'(d_pc[k]), 32'(e_pc));
                chk("ifid_stall", k, 32'(d_ifs[k]), 32'(e_ifs));
                chk("ifid_flush", k, 32'(d_iff[k]), 32'(e_iff));
                chk("idex_stall", k, 32'(d_ids[k]), 32'(e_ids));
                chk("idex_flush", k, 32'(d_idf[k]), 32'(e_idf));
                chk("exmem_stall", k, 32'(d_exs[k]), 32'(e_exs));
                if (rst) begin
                    m_rem[k] = 0; m_hz[k] = 0; m_sc[k] = 0; m_bc[k] = 0; m_rc[k] = 0;
                end else begin
                    m_rem[k] = n_rem;
                    m_hz[k]  = n_hz;
                    if (e_pc) m_sc[k] = (m_sc[k] + 1) & mask[k];
                    if (e_pc && e_idf) m_bc[k] = (m_bc[k] + 1) & mask[k];
                    if (e_iff) m_rc[k] = (m_rc[k] + 1) & mask[k];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_wa = 5'd0; ex_regWrite = 1'b0; ex_memOrReg = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] wa);
        id_valid = 1'b1; id_rs1 = wa; id_use_rs1 = 1'b1; id_rs2 = 5'd31; id_use_rs2 = 1'b0;
        ex_wa = wa; ex_regWrite = 1'b1; ex_memOrReg = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        next_cycle();
        chk_en = 1'b1;

        // Reset state, second reset cycle
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ifid_flush", k, 32'(d_iff[k]), 32'd1);
            chk("rst_idex_flush", k, 32'(d_idf[k]), 32'd1);
            chk("rst_pc_stall", k, 32'(d_pc[k]), 32'd0);
            chk("rst_hz", k, 32'(d_hz[k]), 32'd0);
            chk("rst_sc", k, d_sc[k], 32'd0);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_flush", 1, 32'(d_iff[1]), 32'd0);
        chk("idle_pc", 1, 32'(d_pc[1]), 32'd0);

        // Load-use on x5
        do_reset();
        set_lu(5'd5);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lu_pc", k, 32'(d_pc[k]), 32'd1);
            chk("lu_ifs", k, 32'(d_ifs[k]), 32'd1);
            chk("lu_idf", k, 32'(d_idf[k]), 32'd1);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("lu1_done_pc", 0, 32'(d_pc[0]), 32'd0);
        chk("lu1_bubbles", 0, d_bc[0], 32'd1);
        chk("lu3_b2_pc", 1, 32'(d_pc[1]), 32'd1);
        chk("lu3_b2_hz", 1, 32'(d_hz[1]), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lu3_b3_pc", 1, 32'(d_pc[1]), 32'd1);
        chk("lu3_b3_hz", 1, 32'(d_hz[1]), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lu3_done_pc", 1, 32'(d_pc[1]), 32'd0);
        chk("lu3_done_hz", 1, 32'(d_hz[1]), 32'd0);
        chk("lu3_bubbles", 1, d_bc[1], 32'd3);
        chk("lu3_stalls", 1, d_sc[1], 32'd3);

        // Load into x0 never stalls
        set_lu(5'd0);
        @(negedge clk);
        chk("x0_pc", 0, 32'(d_pc[0]), 32'd0);
        chk("x0_pc", 1, 32'(d_pc[1]), 32'd0);
        next_cycle();
        drive_idle();

        // Redirect coincident with load-use
        do_reset();
        set_lu(5'd7);
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("rdlu_iff", 1, 32'(d_iff[1]), 32'd1);
        chk("rdlu_idf", 1, 32'(d_idf[1]), 32'd1);
        chk("rdlu_pc", 1, 32'(d_pc[1]), 32'd0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("rdlu_rc", 1, d_rc[1], 32'd1);
        chk("rdlu_bc", 1, d_bc[1], 32'd0);
        chk("rdlu_pc_after", 1, 32'(d_pc[1]), 32'd0);

        // mem_busy in the middle of a 3-bubble stall
        do_reset();
        set_lu(5'd9);
        @(negedge clk);
        next_cycle();
        drive_idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_pc", 1, 32'(d_pc[1]), 32'd1);
            chk("busy_exs", 1, 32'(d_exs[1]), 32'd1);
            chk("busy_idf", 1, 32'(d_idf[1]), 32'd0);
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("resume_b2_idf", 1, 32'(d_idf[1]), 32'd1);
        chk("resume_b2_exs", 1, 32'(d_exs[1]), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("resume_b3_pc", 1, 32'(d_pc[1]), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("resume_done_pc", 1, 32'(d_pc[1]), 32'd0);
        chk("busy_stalls", 1, d_sc[1], 32'd7);
        chk("busy_bubbles", 1, d_bc[1], 32'd3);
        chk("busy_stalls", 0, d_sc[0], 32'd5);

        // Reset during LU_STALL
        do_reset();
        set_lu(5'd3);
        @(negedge clk);
        next_cycle();
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_iff", 1, 32'(d_iff[1]), 32'd1);
        chk("midrst_pc", 1, 32'(d_pc[1]), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_pc", 1, 32'(d_pc[1]), 32'd0);
        chk("midrst_after_hz", 1, 32'(d_hz[1]), 32'd0);
        next_cycle();

        // Redirect held under mem_busy
        do_reset();
        ex_redirect = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rdbusy_iff", 1, 32'(d_iff[1]), 32'd0);
            chk("rdbusy_pc", 1, 32'(d_pc[1]), 32'd1);
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("rd_release_iff", 1, 32'(d_iff[1]), 32'd1);
        chk("rd_release_pc", 1, 32'(d_pc[1]), 32'd0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("rd_release_rc", 1, d_rc[1], 32'd1);
        chk("rd_release_sc", 1, d_sc[1], 32'd2);

        // Randomized phase; registers drawn from a small pool to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst         = ($urandom_range(0, 99) < 2);
            mem_busy    = ($urandom_range(0, 99) < 15);
            ex_redirect = ($urandom_range(0, 99) < 10);
            id_valid    = ($urandom_range(0, 9) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_wa       = 5'($urandom_range(0, 3));
            ex_regWrite = ($urandom_range(0, 3) != 0);
            ex_memOrReg = ($urandom_range(0, 1) != 0);
        end
        next_cycle();
        drive_idle();
        repeat (5) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Drives the stall and flush (bubble-inject) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC-hold input.
- Detects load-use hazards between the decoded instruction and an in-flight load, and holds the pipeline for LOAD_LAT bubbles.
- Freezes the whole pipeline while data memory is busy.
- Squashes wrong-path instructions when EX resolves a taken branch or a jump.
- Keeps performance counters.

Parameters:
- LOAD_LAT, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_wa  in  5  EX-stage destination register
- ex_regWrite  in  1  EX instruction writes the register file
- ex_memOrReg  in  1  EX instruction is a load (result comes from memory)
- ex_redirect  in  1  EX taken branch or jump (branch&taken | jump)
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  load NOP into ID/EX
- exmem_stall  out  1  hold EX/MEM
- hz_state  out  2  current FSM state, for debug
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1
- bubble_cnt  out  CNT_W  count of load-use bubbles injected
- redirect_cnt  out  CNT_W  count of redirects honoured

Behaviour:
- Stall/flush outputs are combinational from state and inputs. State, the bubble counter and the perf counters are registered.
- A given register never sees stall=1 and flush=1 in the same cycle. Stall takes priority inside the pipeline registers, so a simultaneous flush would be lost.
- Hazard definition: LU = id_valid & ex_regWrite & ex_memOrReg & ex_wa!=0 & ((id_use_rs1 & id_rs1==ex_wa) | (id_use_rs2 & id_rs2==ex_wa)). Register x0 never causes a hazard.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2. Encoding 3 is unused and recovers to RUN.
- Per-cycle priority:
  1. rst.
  2. mem_busy.
  3. ex_redirect.
  4. LU or LU_STALL.
  5. Normal.
- rst=1:
  - ifid_flush=1, idex_flush=1, all stalls 0.
  - Next state RUN, bubble counter 0, all perf counters 0, hz_state=0.
  - Reset asserted mid-stall abandons the stall with no residual bubbles.
- mem_busy=1 (any state):
  - pc_stall, ifid_stall, idex_stall, exmem_stall all 1; both flushes 0.
  - Next state MEM_WAIT. The bubble counter holds its value.
  - Redirect and LU evaluation are suppressed. A redirect in EX stays frozen and is honoured the first cycle mem_busy=0.
- MEM_WAIT with mem_busy=0: evaluate exactly as RUN would, using the held bubble counter.
  - If counter>0, behave as LU_STALL.
  - Otherwise behave as RUN.
- ex_redirect=1 (not busy):
  - ifid_flush=1, idex_flush=1, stalls 0.
  - redirect_cnt increments. The bubble counter clears and next state is RUN.
  - A coincident LU is ignored because the ID instruction is wrong-path.
- RUN with LU:
  - pc_stall=1, ifid_stall=1, idex_flush=1.
  - bubble_cnt increments.
  - Counter loads LOAD_LAT-1. Next state is LU_STALL if LOAD_LAT>1, otherwise RUN.
- LU_STALL:
  - Same outputs as the LU case. bubble_cnt increments and the counter decrements.
  - When the counter reaches 0 after the decrement, next state is RUN.
  - LU is not re-evaluated while in LU_STALL.
  - After the final bubble, RUN re-evaluates LU normally. A back-to-back load hazard therefore re-triggers.
- Normal: all outputs 0.
- Counters:
  - stall_cycles increments every cycle pc_stall=1 and rst=0.
  - All counters wrap modulo 2^CNT_W.
  - Counter values are visible the cycle after the event.

Test Plan:
- Reset: rst=1 for 2 cycles → ifid_flush=idex_flush=1, all stalls 0, all counters 0, hz_state=0. Then rst=0 with no hazards → all outputs 0.
- Load-use, LOAD_LAT=1: ex_wa=5, ex_regWrite=1, ex_memOrReg=1, id_rs1=5, id_use_rs1=1 for one cycle → pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, bubble_cnt=1. Repeat with ex_wa=0 → no stall.
- Load-use, LOAD_LAT=3: same stimulus → 3 consecutive bubble cycles, hz_state 1,1,0, bubble_cnt=3, stall_cycles=3.
- Redirect vs LU: ex_redirect=1 in the same cycle as LU → ifid_flush=idex_flush=1, no stall, redirect_cnt=1, bubble_cnt=0.
- mem_busy: assert for 4 cycles in the middle of a LOAD_LAT=3 stall, after its 1st bubble cycle → 4 cycles with all four stalls=1 and no flush, then the 2 remaining bubbles, stall_cycles=7.
- Reset mid-stall and redirect under busy:
  - rst=1 during LU_STALL → next cycle RUN, no further bubbles.
  - ex_redirect=1 with mem_busy=1 for 2 cycles → flush only on the cycle mem_busy drops.
